// File: rtl/ex_muldiv_seq.sv
// Iterative unsigned 32-bit multiply/divide unit: 32 cycles in RUN, result valid on a one-cycle done pulse.
// Optional MULDIV_EARLY_OUT_EN finishes zero-operand MUL/MULHU and divide-by-zero DIVU/REMU in a single RUN cycle.
module ex_muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rdAddr_in,
    input  logic        flush,
    output logic        stall_ex,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rdAddr_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        accept;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [32:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] step_next;
    logic        early;
    logic [63:0] early_acc;

    assign accept   = start & (state_q != S_RUN) & ~flush;
    assign stall_ex = accept | ((state_q == S_RUN) & ~flush);

    // acc holds {product hi, multiplier/product lo} for MUL and {remainder, dividend/quotient} for DIV,
    // so the high/low select by op[0] is the same for both families.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
        div_next  = {div_rem[31:0], acc_q[30:0], div_ge};
        step_next = op_q[1] ? div_next : mul_next;
        early_acc = op_q[1] ? {a_q, 32'hFFFF_FFFF} : 64'd0;
`ifdef MULDIV_EARLY_OUT_EN
        early     = (cnt_q == 6'd0) &
                    (op_q[1] ? (b_q == 32'd0) : ((a_q == 32'd0) || (b_q == 32'd0)));
`else
        early     = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = early ? early_acc : step_next;
                    cnt_d = cnt_q + 6'd1;
                    if (early || (cnt_q == 6'd31)) begin
                        state_d  = S_DONE;
                        result_d = op_q[0] ? acc_d[63:32] : acc_d[31:0];
                        rd_out_d = rd_q;
                    end
                end
            end
            default: begin
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = 6'd0;
                    op_d    = op;
                    a_d     = opA;
                    b_d     = opB;
                    rd_d    = rdAddr_in;
                    acc_d   = op[1] ? {32'd0, opA} : {32'd0, opB};
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            rd_q     <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign rdAddr_out = rd_out_q;

endmodule
